// File: rtl/ahb_pkg.sv
// Shared AHB-Lite types and constants for the single-master decoder/mux interconnect.
package ahb_pkg;

  typedef enum logic [1:0] {
    HT_IDLE   = 2'b00,
    HT_BUSY   = 2'b01,
    HT_NONSEQ = 2'b10,
    HT_SEQ    = 2'b11
  } htrans_t;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } xbar_st_t;

  // Data-phase select is wide enough to hold every real slave index plus the default slave.
  localparam int DSEL_W = 5;
  localparam logic [DSEL_W-1:0] DEF_SLV = 5'd16;

endpackage

// File: rtl/ahb_wdog_cnt.sv
// Saturating wait-state counter for the active data phase; pulses trip on the last allowed wait.
module ahb_wdog_cnt #(
  parameter int TIMEOUT = 256
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic inc,
  output logic trip
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + CW'(1);
    end
  end

  // TIMEOUT of zero disables the watchdog entirely.
  assign trip = (TIMEOUT > 0) && inc && (cnt == LAST);

endmodule

// File: rtl/ahb_lite_decoder_mux.sv
// Single-master AHB-Lite interconnect: address decode, HSEL fan-out, response mux,
// built-in default slave and a shared wait-state watchdog that quarantines hung slaves.
module ahb_lite_decoder_mux
  import ahb_pkg::*;
#(
  parameter int NUM_SLV = 4,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int DEC_LSB = 12,
  parameter int DEC_W   = 4,
  parameter int TIMEOUT = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [AW-1:0]         m_haddr_i,
  input  logic [1:0]            m_htrans_i,
  input  logic                  m_hwrite_i,
  input  logic [2:0]            m_hsize_i,
  input  logic [2:0]            m_hburst_i,
  input  logic [3:0]            m_hprot_i,
  input  logic                  m_hmastlock_i,
  input  logic [DW-1:0]         m_hwdata_i,
  output logic                  m_hready_o,
  output logic                  m_hresp_o,
  output logic [DW-1:0]         m_hrdata_o,
  output logic [NUM_SLV-1:0]    s_hsel_o,
  output logic [AW-1:0]         s_haddr_o,
  output logic [1:0]            s_htrans_o,
  output logic                  s_hwrite_o,
  output logic [2:0]            s_hsize_o,
  output logic [2:0]            s_hburst_o,
  output logic [3:0]            s_hprot_o,
  output logic                  s_hmastlock_o,
  output logic [DW-1:0]         s_hwdata_o,
  output logic                  s_hreadyin_o,
  input  logic [NUM_SLV-1:0]    s_hreadyout_i,
  input  logic [NUM_SLV-1:0]    s_hresp_i,
  input  logic [NUM_SLV*DW-1:0] s_hrdata_i,
  output logic [NUM_SLV-1:0]    hung_o
);

  xbar_st_t            state, state_nx;
  logic [DSEL_W-1:0]   dsel;
  logic [NUM_SLV-1:0]  hung;
  logic [NUM_SLV-1:0]  dsel_hit;
  logic [DEC_W-1:0]    idx;
  logic                sel_valid;
  logic [DSEL_W-1:0]   target;
  logic                accept;
  logic                slv_ready;
  logic                slv_resp;
  logic [DW-1:0]       slv_rdata;
  logic                wd_inc;
  logic                wd_trip;

  assign s_haddr_o     = m_haddr_i;
  assign s_htrans_o    = m_htrans_i;
  assign s_hwrite_o    = m_hwrite_i;
  assign s_hsize_o     = m_hsize_i;
  assign s_hburst_o    = m_hburst_i;
  assign s_hprot_o     = m_hprot_i;
  assign s_hmastlock_o = m_hmastlock_i;
  assign s_hwdata_o    = m_hwdata_i;
  assign s_hreadyin_o  = m_hready_o;
  assign hung_o        = hung;

  assign idx = m_haddr_i[DEC_LSB +: DEC_W];

  // A hung slave is hidden from decode so its accesses fall through to the default slave.
  for (genvar g = 0; g < NUM_SLV; g++) begin : g_slv
    assign s_hsel_o[g] = (idx == DEC_W'(g)) && !hung[g];
    assign dsel_hit[g] = (dsel == DSEL_W'(g));
  end

  assign sel_valid = |s_hsel_o;
  assign target    = sel_valid ? DSEL_W'(idx) : DEF_SLV;
  assign accept    = m_hready_o && ((m_htrans_i == HT_NONSEQ) || (m_htrans_i == HT_SEQ));

  always_comb begin
    slv_ready = 1'b0;
    slv_resp  = HRESP_OKAY;
    slv_rdata = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (dsel_hit[i]) begin
        slv_ready = s_hreadyout_i[i];
        slv_resp  = s_hresp_i[i];
        slv_rdata = s_hrdata_i[i*DW +: DW];
      end
    end
  end

  always_comb begin
    m_hready_o = 1'b1;
    m_hresp_o  = HRESP_OKAY;
    m_hrdata_o = '0;
    case (state)
      ST_DATA: begin
        m_hready_o = slv_ready;
        m_hresp_o  = slv_resp;
        m_hrdata_o = slv_rdata;
      end
      ST_ERR1: begin
        m_hready_o = 1'b0;
        m_hresp_o  = HRESP_ERROR;
      end
      ST_ERR2: begin
        m_hready_o = 1'b1;
        m_hresp_o  = HRESP_ERROR;
      end
      default: ;
    endcase
  end

  assign wd_inc = (state == ST_DATA) && !slv_ready;

  ahb_wdog_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk   (clk),
    .reset (reset),
    .clear (accept),
    .inc   (wd_inc),
    .trip  (wd_trip)
  );

  // ERR2 completes like any data phase, so a new address may be accepted during it.
  always_comb begin
    state_nx = state;
    case (state)
      ST_ERR1: state_nx = ST_ERR2;
      default: begin
        if (m_hready_o) begin
          if (accept) state_nx = sel_valid ? ST_DATA : ST_ERR1;
          else        state_nx = ST_IDLE;
        end else if (wd_trip) begin
          state_nx = ST_ERR1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      dsel  <= '0;
    end else begin
      state <= state_nx;
      if (accept) dsel <= target;
    end
  end

  // Quarantine is released once the slave shows ready while it is not the active target.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hung <= '0;
    end else begin
      for (int i = 0; i < NUM_SLV; i++) begin
        if (wd_trip && dsel_hit[i])
          hung[i] <= 1'b1;
        else if (s_hreadyout_i[i] && ((state == ST_IDLE) || !dsel_hit[i]))
          hung[i] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ahb_lite_decoder_mux.sv
// Directed self-checking bench for ahb_lite_decoder_mux with four slaves and an 8-cycle watchdog.
module tb_ahb_lite_decoder_mux;
  import ahb_pkg::*;

  localparam int NUM_SLV = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic                  clk;
  logic                  reset;
  logic [AW-1:0]         m_haddr;
  logic [1:0]            m_htrans;
  logic                  m_hwrite;
  logic [2:0]            m_hsize;
  logic [2:0]            m_hburst;
  logic [3:0]            m_hprot;
  logic                  m_hmastlock;
  logic [DW-1:0]         m_hwdata;
  logic                  m_hready;
  logic                  m_hresp;
  logic [DW-1:0]         m_hrdata;
  logic [NUM_SLV-1:0]    s_hsel;
  logic [AW-1:0]         s_haddr;
  logic [1:0]            s_htrans;
  logic                  s_hwrite;
  logic [2:0]            s_hsize;
  logic [2:0]            s_hburst;
  logic [3:0]            s_hprot;
  logic                  s_hmastlock;
  logic [DW-1:0]         s_hwdata;
  logic                  s_hreadyin;
  logic [NUM_SLV-1:0]    s_hreadyout;
  logic [NUM_SLV-1:0]    s_hresp;
  logic [NUM_SLV*DW-1:0] s_hrdata;
  logic [NUM_SLV-1:0]    hung;

  int n_compared;
  int n_mismatched;

  ahb_lite_decoder_mux #(
    .NUM_SLV (NUM_SLV),
    .AW      (AW),
    .DW      (DW),
    .DEC_LSB (12),
    .DEC_W   (4),
    .TIMEOUT (8)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .m_haddr_i     (m_haddr),
    .m_htrans_i    (m_htrans),
    .m_hwrite_i    (m_hwrite),
    .m_hsize_i     (m_hsize),
    .m_hburst_i    (m_hburst),
    .m_hprot_i     (m_hprot),
    .m_hmastlock_i (m_hmastlock),
    .m_hwdata_i    (m_hwdata),
    .m_hready_o    (m_hready),
    .m_hresp_o     (m_hresp),
    .m_hrdata_o    (m_hrdata),
    .s_hsel_o      (s_hsel),
    .s_haddr_o     (s_haddr),
    .s_htrans_o    (s_htrans),
    .s_hwrite_o    (s_hwrite),
    .s_hsize_o     (s_hsize),
    .s_hburst_o    (s_hburst),
    .s_hprot_o     (s_hprot),
    .s_hmastlock_o (s_hmastlock),
    .s_hwdata_o    (s_hwdata),
    .s_hreadyin_o  (s_hreadyin),
    .s_hreadyout_i (s_hreadyout),
    .s_hresp_i     (s_hresp),
    .s_hrdata_i    (s_hrdata),
    .hung_o        (hung)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic [31:0] addr, input logic [1:0] trans);
    m_haddr  = addr;
    m_htrans = trans;
    #2;
  endtask

  task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_compared++;
    assert (observed === expected) else begin
      n_mismatched++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      $error("[TB] check %s differs", tag);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL global_timeout observed=running expected=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    reset        = 1'b1;
    m_haddr      = 32'h0000_7000;
    m_htrans     = HT_IDLE;
    m_hwrite     = 1'b0;
    m_hsize      = 3'b010;
    m_hburst     = 3'b000;
    m_hprot      = 4'b0011;
    m_hmastlock  = 1'b0;
    m_hwdata     = '0;
    s_hreadyout  = 4'b1111;
    s_hresp      = 4'b0000;
    s_hrdata     = {32'hCAFE_0003, 32'hCAFE_0002, 32'hCAFE_0001, 32'hCAFE_0000};

    // Reset state
    tick();
    tick();
    check_output("rst_hready", m_hready, 1);
    check_output("rst_hresp", m_hresp, 0);
    check_output("rst_hrdata", m_hrdata, 0);
    check_output("rst_hsel", s_hsel, 0);
    check_output("rst_hung", hung, 0);
    reset = 1'b0;

    // Single zero-wait read from slave 2
    apply_stimulus(32'h0000_2004, HT_NONSEQ);
    check_output("t1_hsel", s_hsel, 4'b0100);
    check_output("t1_addr_hready", m_hready, 1);
    check_output("t1_bcast_addr", s_haddr, 32'h0000_2004);
    tick();
    apply_stimulus(32'h0000_7000, HT_IDLE);
    check_output("t1_rdata", m_hrdata, 32'hCAFE_0002);
    check_output("t1_hready", m_hready, 1);
    check_output("t1_hresp", m_hresp, 0);
    tick();

    // Slave 0 with three waits, slave 3 address held meanwhile
    apply_stimulus(32'h0000_0000, HT_NONSEQ);
    check_output("t2_hsel0", s_hsel, 4'b0001);
    tick();
    s_hreadyout = 4'b1110;
    apply_stimulus(32'h0000_3000, HT_NONSEQ);
    check_output("t2_w1_hready", m_hready, 0);
    check_output("t2_w1_hsel3", s_hsel, 4'b1000);
    check_output("t2_w1_hreadyin", s_hreadyin, 0);
    tick();
    check_output("t2_w2_hready", m_hready, 0);
    check_output("t2_w2_hsel3", s_hsel, 4'b1000);
    tick();
    check_output("t2_w3_hready", m_hready, 0);
    check_output("t2_w3_hsel3", s_hsel, 4'b1000);
    tick();
    s_hreadyout = 4'b1111;
    apply_stimulus(32'h0000_3000, HT_NONSEQ);
    check_output("t2_s0_hready", m_hready, 1);
    check_output("t2_s0_rdata", m_hrdata, 32'hCAFE_0000);
    tick();
    apply_stimulus(32'h0000_7000, HT_IDLE);
    check_output("t2_s3_rdata", m_hrdata, 32'hCAFE_0003);
    check_output("t2_s3_hready", m_hready, 1);
    tick();

    // Unmapped slave index 7 -> two-cycle default-slave error
    apply_stimulus(32'h0000_7000, HT_NONSEQ);
    check_output("t3_hsel", s_hsel, 0);
    tick();
    apply_stimulus(32'h0000_7000, HT_IDLE);
    check_output("t3_err1_hready", m_hready, 0);
    check_output("t3_err1_hresp", m_hresp, 1);
    tick();
    check_output("t3_err2_hready", m_hready, 1);
    check_output("t3_err2_hresp", m_hresp, 1);
    tick();
    check_output("t3_idle_hready", m_hready, 1);
    check_output("t3_idle_hresp", m_hresp, 0);

    // IDLE and BUSY to an unmapped address stay OKAY
    apply_stimulus(32'h0000_7000, HT_BUSY);
    tick();
    check_output("t6_busy_hready", m_hready, 1);
    check_output("t6_busy_hresp", m_hresp, 0);
    apply_stimulus(32'h0000_7000, HT_IDLE);
    tick();
    check_output("t6_idle_hready", m_hready, 1);
    check_output("t6_idle_hresp", m_hresp, 0);

    // Watchdog: slave 1 never ready
    apply_stimulus(32'h0000_1000, HT_NONSEQ);
    check_output("t4_hsel1", s_hsel, 4'b0010);
    tick();
    s_hreadyout = 4'b1101;
    apply_stimulus(32'h0000_7000, HT_IDLE);
    for (int k = 0; k < 8; k++) begin
      check_output("t4_wait_hready", m_hready, 0);
      check_output("t4_wait_hresp", m_hresp, 0);
      tick();
    end
    check_output("t4_err1_hready", m_hready, 0);
    check_output("t4_err1_hresp", m_hresp, 1);
    check_output("t4_hung_set", hung, 4'b0010);
    tick();
    apply_stimulus(32'h0000_1000, HT_NONSEQ);
    check_output("t4_err2_hready", m_hready, 1);
    check_output("t4_err2_hresp", m_hresp, 1);
    check_output("t4_hung_hsel", s_hsel, 0);
    tick();
    apply_stimulus(32'h0000_7000, HT_IDLE);
    check_output("t4_def_err1_hready", m_hready, 0);
    check_output("t4_def_err1_hresp", m_hresp, 1);
    tick();
    check_output("t4_def_err2_hresp", m_hresp, 1);
    check_output("t4_hung_held", hung, 4'b0010);
    s_hreadyout = 4'b1111;
    apply_stimulus(32'h0000_7000, HT_IDLE);
    tick();
    check_output("t4_hung_clear", hung, 0);
    apply_stimulus(32'h0000_1000, HT_NONSEQ);
    check_output("t4_hsel1_back", s_hsel, 4'b0010);
    tick();
    apply_stimulus(32'h0000_7000, HT_IDLE);
    check_output("t4_s1_rdata", m_hrdata, 32'hCAFE_0001);
    check_output("t4_s1_hresp", m_hresp, 0);
    check_output("t4_s1_hready", m_hready, 1);
    tick();

    // Reset asserted while slave 2 is mid-wait
    apply_stimulus(32'h0000_2000, HT_NONSEQ);
    tick();
    s_hreadyout = 4'b1011;
    apply_stimulus(32'h0000_7000, HT_IDLE);
    check_output("t5_wait_hready", m_hready, 0);
    tick();
    reset = 1'b1;
    #1;
    check_output("t5_rst_hready", m_hready, 1);
    check_output("t5_rst_hresp", m_hresp, 0);
    tick();
    reset = 1'b0;
    s_hreadyout = 4'b1111;
    apply_stimulus(32'h0000_7000, HT_IDLE);
    check_output("t5_post_hready", m_hready, 1);
    check_output("t5_post_rdata", m_hrdata, 0);
    check_output("t5_post_hsel", s_hsel, 0);
    check_output("t5_post_hung", hung, 0);
    apply_stimulus(32'h0000_2004, HT_NONSEQ);
    tick();
    apply_stimulus(32'h0000_7000, HT_IDLE);
    check_output("t5_s2_rdata", m_hrdata, 32'hCAFE_0002);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
